// File: rtl/conv_accumulator.sv
// conv_accumulator: sums TAPS samples into one pixel, then rounds, shifts,
// saturates and optionally rectifies it. Pixels queue in a small FIFO that
// drains through a valid/ready output handshake.
module conv_accumulator #(
    parameter int unsigned TAPS  = 9,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned RELU  = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] res_data,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic               clear,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         tap_count,
    output logic               sat_flag
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = AW + 1;
    // Half an LSB of the shifted result; zero when there is no shift.
    localparam int unsigned RND  = (32'd1 << SHIFT) >> 1;
    localparam int unsigned LAST = TAPS - 1;

    logic signed [31:0] acc;
    logic signed [31:0] sample_ext;
    logic signed [31:0] sum;
    logic signed [31:0] rounded;
    logic signed [15:0] pixel;
    logic               pixel_sat;

    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    logic accept;
    logic last_tap;
    logic push;
    logic pop;

    // Handshake qualifiers; res_ready depends only on the registered count.
    assign res_ready = (count < CW'(DEPTH));
    assign accept    = res_valid && res_ready;
    assign last_tap  = (tap_count == 8'(LAST));
    assign push      = accept && last_tap && !clear;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Completed-pixel datapath: sum, round, shift, saturate, rectify.
    always_comb begin
        sample_ext = {{16{res_data[15]}}, res_data};
        sum        = acc + sample_ext;
        rounded    = (sum + $signed(32'(RND))) >>> SHIFT;
        pixel      = rounded[15:0];
        pixel_sat  = 1'b0;
        if (rounded > 32'sd32767) begin
            pixel     = 16'sh7fff;
            pixel_sat = 1'b1;
        end else if (rounded < -32'sd32768) begin
            pixel     = 16'sh8000;
            pixel_sat = 1'b1;
        end
        if ((RELU != 0) && pixel[15]) begin
            pixel = '0;
        end
    end

    // Accumulator and tap counter; clear wins over an accept in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc       <= '0;
            tap_count <= '0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            tap_count <= '0;
        end else if (accept) begin
            if (last_tap) begin
                acc       <= '0;
                tap_count <= '0;
                if (pixel_sat) begin
                    sat_flag <= 1'b1;
                end
            end else begin
                acc       <= sum;
                tap_count <= 8'(tap_count + 8'd1);
            end
        end
    end

    // Output FIFO: registered storage, pointers wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= pixel;
                wr_ptr      <= AW'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            case ({push, pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: four instances cover the base
// configuration, shift/saturation, rectification and a single-tap FIFO.
module tb_conv_accumulator;

    logic clock;
    logic reset;

    logic signed [15:0] rdat [4];
    logic               rval [4];
    logic               clr  [4];
    logic               ordy [4];
    logic               rrdy [4];
    logic signed [15:0] odat [4];
    logic               oval [4];
    logic [7:0]         tcnt [4];
    logic               sat  [4];

    int checks;
    int errors;

    // 0: base, 1: SHIFT=2, 2: RELU=1, 3: TAPS=1
    conv_accumulator #(.TAPS(9), .SHIFT(0), .RELU(0), .DEPTH(4)) u_base (
        .clock(clock), .reset(reset), .res_data(rdat[0]), .res_valid(rval[0]),
        .res_ready(rrdy[0]), .clear(clr[0]), .out_data(odat[0]), .out_valid(oval[0]),
        .out_ready(ordy[0]), .tap_count(tcnt[0]), .sat_flag(sat[0]));

    conv_accumulator #(.TAPS(9), .SHIFT(2), .RELU(0), .DEPTH(4)) u_shift (
        .clock(clock), .reset(reset), .res_data(rdat[1]), .res_valid(rval[1]),
        .res_ready(rrdy[1]), .clear(clr[1]), .out_data(odat[1]), .out_valid(oval[1]),
        .out_ready(ordy[1]), .tap_count(tcnt[1]), .sat_flag(sat[1]));

    conv_accumulator #(.TAPS(9), .SHIFT(0), .RELU(1), .DEPTH(4)) u_relu (
        .clock(clock), .reset(reset), .res_data(rdat[2]), .res_valid(rval[2]),
        .res_ready(rrdy[2]), .clear(clr[2]), .out_data(odat[2]), .out_valid(oval[2]),
        .out_ready(ordy[2]), .tap_count(tcnt[2]), .sat_flag(sat[2]));

    conv_accumulator #(.TAPS(1), .SHIFT(0), .RELU(0), .DEPTH(4)) u_tap1 (
        .clock(clock), .reset(reset), .res_data(rdat[3]), .res_valid(rval[3]),
        .res_ready(rrdy[3]), .clear(clr[3]), .out_data(odat[3]), .out_valid(oval[3]),
        .out_ready(ordy[3]), .tap_count(tcnt[3]), .sat_flag(sat[3]));

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive n back-to-back valid samples of value v into instance i
    task automatic feed(input int i, input int v, input int n);
        for (int k = 0; k < n; k++) begin
            rdat[i] = 16'(v);
            rval[i] = 1'b1;
            tick();
        end
        rval[i] = 1'b0;
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdat[i] = '0;
            rval[i] = 1'b0;
            clr[i]  = 1'b0;
            ordy[i] = 1'b1;
        end
        ordy[3] = 1'b0;
        tick();
        tick();
        chk("rst_out_data", odat[0], 0);
        chk("rst_out_valid", oval[0], 0);
        chk("rst_res_ready", rrdy[0], 1);
        chk("rst_tap_count", tcnt[0], 0);
        chk("rst_sat_flag", sat[0], 0);
        reset = 1'b1;
        tick();

        // Basic sum: nine 100s -> 900
        for (int k = 0; k < 9; k++) begin
            chk("basic_tap_count", tcnt[0], k);
            chk("basic_no_valid", oval[0], 0);
            rdat[0] = 16'sd100;
            rval[0] = 1'b1;
            tick();
        end
        rval[0] = 1'b0;
        chk("basic_valid", oval[0], 1);
        chk("basic_data", odat[0], 900);
        chk("basic_tap_wrap", tcnt[0], 0);
        tick();
        chk("basic_popped", oval[0], 0);

        // Rounding: 1,1,0x7 with SHIFT=2 -> (2+2)>>2 = 1
        feed(1, 1, 2);
        feed(1, 0, 7);
        chk("round_data", odat[1], 1);
        chk("round_valid", oval[1], 1);
        chk("round_no_sat", sat[1], 0);
        // Positive saturation: 270000 -> 67500 -> 32767
        feed(1, 30000, 9);
        chk("satpos_data", odat[1], 32767);
        chk("satpos_flag", sat[1], 1);
        // Negative saturation: -270000 -> -67500 -> -32768
        feed(1, -30000, 9);
        chk("satneg_data", odat[1], -32768);
        chk("satneg_flag_sticky", sat[1], 1);

        // RELU: -45 -> 0, then 10-3 -> 7
        feed(2, -5, 9);
        chk("relu_neg_valid", oval[2], 1);
        chk("relu_neg_data", odat[2], 0);
        feed(2, 10, 1);
        feed(2, -3, 1);
        feed(2, 0, 7);
        chk("relu_pos_data", odat[2], 7);

        // Backpressure: fill four entries with out_ready low
        feed(3, 11, 1);
        feed(3, 22, 1);
        feed(3, 33, 1);
        chk("bp_ready_3", rrdy[3], 1);
        feed(3, 44, 1);
        chk("bp_ready_full", rrdy[3], 0);
        chk("bp_head", odat[3], 11);
        feed(3, 55, 1);
        chk("bp_still_full", rrdy[3], 0);
        chk("bp_head_hold", odat[3], 11);
        ordy[3] = 1'b1;
        tick();
        ordy[3] = 1'b0;
        chk("bp_ready_back", rrdy[3], 1);
        chk("bp_drain_1", odat[3], 22);
        ordy[3] = 1'b1;
        tick();
        chk("bp_drain_2", odat[3], 33);
        tick();
        chk("bp_drain_3", odat[3], 44);
        tick();
        chk("bp_empty", oval[3], 0);
        ordy[3] = 1'b0;

        // Simultaneous push/pop with two entries queued
        feed(3, 1, 1);
        feed(3, 2, 1);
        rdat[3] = 16'sd3;
        rval[3] = 1'b1;
        ordy[3] = 1'b1;
        tick();
        rval[3] = 1'b0;
        chk("pp_head", odat[3], 2);
        chk("pp_valid", oval[3], 1);
        tick();
        chk("pp_next", odat[3], 3);
        tick();
        chk("pp_empty", oval[3], 0);
        ordy[3] = 1'b0;

        // Clear mid-pixel drops the accompanying sample
        feed(0, 50, 4);
        chk("clr_taps_before", tcnt[0], 4);
        clr[0]  = 1'b1;
        rdat[0] = 16'sd50;
        rval[0] = 1'b1;
        tick();
        clr[0]  = 1'b0;
        rval[0] = 1'b0;
        chk("clr_tap_count", tcnt[0], 0);
        chk("clr_ready", rrdy[0], 1);
        chk("clr_no_valid", oval[0], 0);
        feed(0, 10, 9);
        chk("clr_sum", odat[0], 90);
        tick();

        // Reset mid-pixel with a FIFO entry pending elsewhere
        feed(3, 77, 1);
        feed(0, 50, 4);
        chk("rst2_pending", oval[3], 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst2_tap_count", tcnt[0], 0);
        chk("rst2_out_valid", oval[0], 0);
        chk("rst2_out_data", odat[0], 0);
        chk("rst2_res_ready", rrdy[0], 1);
        chk("rst2_fifo_flush", oval[3], 0);
        chk("rst2_sat_cleared", sat[1], 0);
        feed(0, 10, 9);
        chk("rst2_sum", odat[0], 90);
        chk("rst2_valid", oval[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Downstream of the convolution datapath. Consumes the per-cycle 16-bit product/result stream (`RMat`, qualified by a valid delayed from the controller's `datap_sel`) and sums TAPS accepted samples into one output pixel. It rounds, shifts, saturates and optionally rectifies each completed pixel, then buffers it in a small FIFO behind a valid/ready output handshake. Backpressure is reported upstream through `res_ready` so the controller can hold `datap_sel`.

## Interface
- TAPS, 9: samples per output pixel (kernel size); legal range 1–256.
- SHIFT, 0: arithmetic right shift applied to each completed sum; legal range 0–15.
- RELU, 0: when 1, negative results are forced to 0 after saturation.
- DEPTH, 4: output FIFO entries; power of two, at least 2.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state.
- res_data  in  16  signed two's-complement sample from the datapath result register.
- res_valid  in  1  `res_data` is valid this cycle.
- res_ready  out  1  block can accept a sample; equals (fifo_count < DEPTH).
- clear  in  1  synchronous discard of the partial accumulation; FIFO is untouched.
- out_data  out  16  signed pixel at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer takes the head this cycle.
- tap_count  out  8  number of taps accumulated in the current pixel, 0..TAPS-1.
- sat_flag  out  1  sticky; set when any pixel saturated; cleared only by reset.

## Operation
- Accept means `res_valid && res_ready` at a rising edge. Non-accepted samples are ignored with no state change.
- Accumulator: 32-bit signed `acc`; each sample is sign-extended before it is added.
- Non-final accept (tap_count < TAPS-1): `acc <= acc + sample`; `tap_count` increments.
- Final accept (tap_count == TAPS-1):
  - `sum = acc + sample`.
  - If SHIFT > 0, `r = (sum + 2^(SHIFT-1)) >>> SHIFT`, which rounds half toward +inf. If SHIFT = 0, `r = sum`.
  - Saturate `r` to [-32768, 32767]. If clipped, set `sat_flag`.
  - If RELU = 1 and the result is negative, force it to 0.
  - Push the result into the FIFO, then set `acc <= 0` and `tap_count <= 0`.
- TAPS = 1: every accept is a final accept.
- `clear` takes priority over an accept in the same cycle: `acc <= 0`, `tap_count <= 0`, and the sample is dropped. `res_ready` is unaffected.
- FIFO is registered, with no fall-through. Pop occurs when `out_valid && out_ready`. Push and pop in the same cycle leave the count unchanged and preserve order.
- Pushes cannot happen while full, because `res_ready` is 0 then. A pop while full raises `res_ready` on the next cycle.
- Two-state control per pixel: ACCUM (tap_count < TAPS-1) and FINAL (the next accept completes the pixel). The state is derived from `tap_count`; no separate FSM is needed.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `res_ready` = 1, `tap_count` = 0, `sat_flag` = 0, `acc` = 0, FIFO empty.
- Reset mid-pixel or with the FIFO non-empty discards everything. The first accept after reset is tap 0.
- Latency: a final accept at edge N makes `out_valid` = 1 with the pixel on `out_data` after edge N.
- Throughput: one sample per cycle while not full; one pixel per TAPS accepts.
- `res_ready` is combinational from the registered FIFO count only, with no path from `res_valid`.
- `out_data`/`out_valid` hold stable while `out_valid && !out_ready`.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
- Upstream contract: the controller asserts `res_valid` two cycles after the `datap_sel` that loaded the operands, and holds operand loads while `res_ready` = 0.

## Test plan
- Basic sum (TAPS=9, SHIFT=0, `out_ready`=1): nine samples of 100 -> one pixel 900, `out_valid` high one cycle after the ninth accept; `tap_count` steps 0..8 then returns to 0.
- Rounding/saturation (SHIFT=2): samples 1,1,0×7 -> 1, since (2+2)>>2 = 1. Then nine samples of 30000 -> (270000+2)>>2 = 67500, which clips to 32767 with `sat_flag` = 1. Nine samples of -30000 -> -32768.
- RELU=1: nine samples of -5 -> 0; mixed 10,-3,0×7 -> 7.
- Backpressure (DEPTH=4, TAPS=1, `out_ready`=0): four accepts fill the FIFO and `res_ready` goes 0. A fifth `res_valid` is ignored. One pop restores `res_ready` the next cycle. Drained order equals input order.
- Simultaneous push/pop: FIFO holding 2 entries, a final accept and a pop in the same cycle -> count stays 2 and ordering is intact.
- Clear and reset mid-pixel: after 4 taps of 50, assert `clear` together with a valid sample -> `tap_count` = 0 and the sample is dropped; nine further 10s -> 90. Repeat with `reset` = 0 instead -> all outputs at reset values and `sat_flag` cleared.
